memory_data_sized: RTL
======================

Name: memory_data_sized

Overview:
- Byte-addressed data memory for the RISC-V datapath.
- Successor to the fixed 64-bit word memory: parametrised width and depth.
- Adds RISC-V access sizes (B/H/W/D), sign/zero extension on loads, byte-lane stores and misalignment detection.
- Read data is registered, and completion is signalled by a request/done handshake.

Parameters:
- BITS, 64, data word width in bits; legal values 32 or 64.
- DEPTH, 32, number of words; must be a power of two.
- ADDR_BITS, $clog2(DEPTH*BITS/8), byte-address width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  access request, sampled on posedge clk when ready=1.
- We  input  1  1 = store, 0 = load; sampled with req.
- funct3  input  3  RISC-V size/sign field: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- endr  input  ADDR_BITS  byte address.
- din  input  BITS  store data; the value sits in the low bytes.
- ready  output  1  block accepts a request this cycle.
- done  output  1  one-cycle pulse: the access accepted on the previous edge completed without fault.
- fault  output  1  one-cycle pulse: the access accepted on the previous edge was rejected.
- dout  output  BITS  load result, valid while done=1 for a load.

Behaviour:
- Reset:
  - While reset=1 at posedge: ready←0, done←0, fault←0, dout←0.
  - ready←1 on the first posedge with reset=0.
  - Memory contents are not cleared by reset; initial contents are undefined.
  - A request in the same cycle as reset is dropped: no write, no done, no fault.
- Addressing:
  - Word index = endr >> log2(BITS/8).
  - Byte offset = endr[log2(BITS/8)-1:0].
  - Size in bytes = 1, 2, 4 or 8 from funct3[1:0].
- Fault conditions (checked on the accepted request):
  - funct3=111.
  - Store with funct3[2]=1.
  - Size 8 when BITS=32.
  - Byte offset not a multiple of the size (misaligned).
  - On fault: no memory write; fault=1 for one cycle; done=0; dout←0.
- Store: on the accepting posedge, write only the size bytes starting at the offset, taking din[8*size-1:0]. Other bytes of the word are unchanged. done=1 on the following cycle; dout←0.
- Load, latency 1:
  - The selected bytes are shifted to bit 0.
  - funct3[2]=0: sign-extend to BITS. funct3[2]=1: zero-extend.
  - Result is registered into dout; done=1 the next cycle.
  - dout holds its value until the next completion, fault or reset.
- Pipelining:
  - ready stays 1 outside reset; back-to-back requests are accepted every cycle.
  - A load issued the cycle after a store to the same word returns the stored bytes (write-then-read ordering).
- req=0: done←0, fault←0, dout holds.
- Wrap-around: none. ADDR_BITS exactly covers DEPTH words, so every address maps to a valid word.

Test Plan:
- Reset held 2 cycles with req=1, We=1, endr=0 → ready=0, done=0, fault=0, dout=0, word 0 unchanged. Release → ready=1 next cycle.
- SD endr=0x08, din=0x8877665544332211, then LD endr=0x08 back-to-back → done=1 both cycles; second dout=0x8877665544332211.
- SB endr=0x09, din=0xAA over the word above, then LBU endr=0x09 → dout=0xAA. Then LB → dout=0xFFFFFFFFFFFFFFAA. Then LD → dout=0x887766554433AA11.
- LH endr=0x0A on the same word → dout=0x0000000000004433. LWU endr=0x0C → dout=0x0000000088776655. LW endr=0x0C → dout=0xFFFFFFFF88776655.
- Misaligned and illegal: SW endr=0x0E; LD endr=0x04; funct3=111; store funct3=100 → fault=1, done=0, dout=0 for each, and memory unchanged (verified by a subsequent LD). With BITS=32, LD endr=0 → fault=1.
- Reset asserted the cycle after an accepted load → done=0, dout=0 that cycle. Memory retains the prior SD data, confirmed by LD after release.

Source files
------------

// File: rtl/memory_data_sized.sv
// Byte-addressed RISC-V data memory: B/H/W/D accesses with sign/zero-extending loads,
// byte-lane stores, misalignment/illegal-size faults and a registered one-cycle completion.
module memory_data_sized #(
  parameter int BITS      = 64,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = $clog2(DEPTH*BITS/8)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 We,
  input  logic [2:0]           funct3,
  input  logic [ADDR_BITS-1:0] endr,
  input  logic [BITS-1:0]      din,
  output logic                 ready,
  output logic                 done,
  output logic                 fault,
  output logic [BITS-1:0]      dout
);

  localparam int OFFB  = $clog2(BITS/8);
  localparam int IDX_W = ADDR_BITS - OFFB;

  logic [BITS-1:0] r_mem [DEPTH];

  logic            r_ready;
  logic            r_done_p1;
  logic            r_fault_p1;
  logic [BITS-1:0] r_dout_p1;

  logic [IDX_W-1:0] w_idx;
  logic [OFFB-1:0]  w_off;
  logic [OFFB-1:0]  w_align;
  logic [OFFB+2:0]  w_shamt;
  logic             w_acc;
  logic             w_fault;
  logic [BITS-1:0]  w_lane;
  logic [BITS-1:0]  w_bmask;
  logic [BITS-1:0]  w_wdata;
  logic [BITS-1:0]  w_rword;
  logic [BITS-1:0]  w_ldata;

  // Ones over the low 8<<sz bits, clamped to the word width.
  function automatic logic [BITS-1:0] f_lane_mask(input logic [1:0] sz);
    logic [BITS-1:0] m;
    int nb;
    nb = 8 << sz;
    for (int i = 0; i < BITS; i++) m[i] = (i < nb);
    return m;
  endfunction

  // Extend the low 8<<sz bits of v to the full word, signed unless uns is set.
  function automatic logic [BITS-1:0] f_extend(input logic [BITS-1:0] v,
                                               input logic [1:0] sz,
                                               input logic uns);
    logic [BITS-1:0] r;
    logic s;
    int nb;
    nb = 8 << sz;
    if (nb > BITS) nb = BITS;
    s = 1'b0;
    for (int i = 0; i < BITS; i++) if (i == nb - 1) s = v[i];
    s = s & ~uns;
    for (int i = 0; i < BITS; i++) r[i] = (i < nb) ? v[i] : s;
    return r;
  endfunction

  // Stage p0: decode the request, detect faults, build lane mask and aligned read data
  always_comb begin
    w_idx   = endr[ADDR_BITS-1:OFFB];
    w_off   = endr[OFFB-1:0];
    w_shamt = {w_off, 3'b000};
    w_acc   = req & r_ready;
    w_align = '0;
    case (funct3[1:0])
      2'd0:    w_align = '0;
      2'd1:    w_align = OFFB'(1);
      2'd2:    w_align = OFFB'(3);
      default: w_align = OFFB'(7);
    endcase
    w_fault = (funct3 == 3'b111)
            | (We & funct3[2])
            | ((BITS == 32) && (funct3[1:0] == 2'd3))
            | ((w_off & w_align) != '0);
    w_lane  = f_lane_mask(funct3[1:0]);
    w_bmask = w_lane << w_shamt;
    w_wdata = din << w_shamt;
    w_rword = r_mem[w_idx];
    w_ldata = f_extend(w_rword >> w_shamt, funct3[1:0], funct3[2]);
  end

  always_ff @(posedge clk) begin
    if (!reset && w_acc && We && !w_fault)
      r_mem[w_idx] <= (r_mem[w_idx] & ~w_bmask) | (w_wdata & w_bmask);
  end

  // Stage p1: registered completion, fault and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_done_p1  <= 1'b0;
      r_fault_p1 <= 1'b0;
      r_dout_p1  <= '0;
    end else begin
      r_ready    <= 1'b1;
      r_done_p1  <= w_acc & ~w_fault;
      r_fault_p1 <= w_acc & w_fault;
      if (w_acc) r_dout_p1 <= (w_fault || We) ? '0 : w_ldata;
    end
  end

  assign ready = r_ready;
  assign done  = r_done_p1;
  assign fault = r_fault_p1;
  assign dout  = r_dout_p1;

endmodule
